// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the imem program loader: FSM states, sync marker, word width.
package imem_loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         DATA_W        = 32;

   typedef enum logic [3:0] {
      IDLE,
      SYNC,
      COUNT,
      BYTE,
      WRITE,
      CHK,
      RELEASE,
      RUN,
      ERR
   } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian word assembler: shifts bytes MSB-first, flags the 4th byte combinationally (no added latency).
// Accepts a byte whenever byte_vld is high; LOADER_CHECKSUM_EN adds a running XOR of all bytes since clr.
module loader_word_asm
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [7:0]        byte_dat,
   output logic [DATA_W-1:0] word_nxt,
   output logic              word_ready
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0]        xor_sum
`endif
);

   logic [23:0] shift_q;
   logic [1:0]  cnt_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (byte_vld) begin
         shift_q <= {shift_q[15:0], byte_dat};
         cnt_q   <= cnt_q + 2'd1;
      end
   end

   // The word is complete in the same cycle its last byte is presented.
   assign word_nxt   = {shift_q, byte_dat};
   assign word_ready = byte_vld && (cnt_q == 2'd3);

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         xor_sum <= '0;
      end else if (byte_vld) begin
         xor_sum <= xor_sum ^ byte_dat;
      end
   end
`endif

endmodule

// File: rtl/imem_prog_loader.sv
// Loads a framed byte stream into the core's imem (one Prog_we per word), then releases the core via reset.
// Byte accept when rx_valid && rx_ready; rx_ready drops during WRITE. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_prog_loader
   import imem_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter int         ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              ProgMode,
   output logic [ADDR_W-1:0] Addr_Prog,
   output logic [31:0]       Data_Prog,
   output logic              Prog_we,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W:0] N_FULL  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [31:0]     GAP_LIM = 32'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   word_idx_q;
   logic [ADDR_W:0]   n_words_q;
   logic [ADDR_W:0]   idx_inc;
   logic [31:0]       gap_q;
   logic              accept;
   logic              in_frame;
   logic              timeout;
   logic [DATA_W-1:0] word_nxt;
   logic              word_ready;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        xor_sum;
`endif

   assign accept   = rx_valid && rx_ready;
   assign idx_inc  = word_idx_q + IDX_ONE;
   assign in_frame = state_q inside {COUNT, BYTE, WRITE, CHK};
   // WRITE keeps counting the gap but cannot itself fault; the following BYTE picks it up.
   assign timeout  = (state_q inside {COUNT, BYTE, CHK}) && !accept && (gap_q >= GAP_LIM);

   loader_word_asm u_word_asm (
      .clk        (clk),
      .reset      (reset),
      .clr        (state_q == COUNT && accept),
      .byte_vld   (state_q == BYTE && accept),
      .byte_dat   (rx_data),
      .word_nxt   (word_nxt),
      .word_ready (word_ready)
`ifdef LOADER_CHECKSUM_EN
      ,
      .xor_sum    (xor_sum)
`endif
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         word_idx_q <= '0;
         n_words_q  <= '0;
         gap_q      <= '0;
         Addr_Prog  <= '0;
         Data_Prog  <= '0;
      end else begin
         state_q <= state_d;
         if (accept || !in_frame) begin
            gap_q <= '0;
         end else if (gap_q != '1) begin
            gap_q <= gap_q + 32'd1;
         end
         if (state_q == COUNT && accept) begin
            n_words_q  <= (rx_data == 8'd0) ? N_FULL : (ADDR_W+1)'(rx_data);
            word_idx_q <= '0;
         end
         // Address and data change together, and only with a complete word.
         if (state_q == BYTE && word_ready) begin
            Addr_Prog <= word_idx_q[ADDR_W-1:0];
            Data_Prog <= word_nxt;
         end
         if (state_q == WRITE) begin
            word_idx_q <= idx_inc;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rx_ready  = 1'b0;
      ProgMode  = 1'b0;
      Prog_we   = 1'b0;
      cpu_reset = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      case (state_q)
         IDLE: begin
            ProgMode  = 1'b1;
            cpu_reset = 1'b0;
            if (start) state_d = SYNC;
         end
         SYNC: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (accept && rx_data == SYNC_BYTE) state_d = COUNT;
         end
         COUNT: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (accept)       state_d = BYTE;
            else if (timeout) state_d = ERR;
         end
         BYTE: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (word_ready)   state_d = WRITE;
            else if (timeout) state_d = ERR;
         end
         WRITE: begin
            Prog_we = 1'b1;
            busy    = 1'b1;
            if (idx_inc == n_words_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = RELEASE;
`endif
            end else begin
               state_d = BYTE;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (accept)       state_d = (rx_data == xor_sum) ? RELEASE : ERR;
            else if (timeout) state_d = ERR;
         end
`endif
         RELEASE: begin
            ProgMode = 1'b1;
            busy     = 1'b1;
            state_d  = RUN;
         end
         RUN: begin
            ProgMode  = 1'b1;
            cpu_reset = 1'b0;
            done      = 1'b1;
            if (start) state_d = SYNC;
         end
         ERR: begin
            error = 1'b1;
            if (start) state_d = SYNC;
         end
         default: state_d = IDLE;
      endcase
      // The core is held in reset for as long as the loader itself is in reset.
      if (reset) cpu_reset = 1'b1;
   end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: table-driven frame loads plus hand-written timeout, reset and checksum sequences.
module tb_imem_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        ProgMode;
   logic [7:0]  Addr_Prog;
   logic [31:0] Data_Prog;
   logic        Prog_we;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;

   always #5 clk = ~clk;

   imem_prog_loader #(
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (50),
      .ADDR_W      (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .ProgMode  (ProgMode),
      .Addr_Prog (Addr_Prog),
      .Data_Prog (Data_Prog),
      .Prog_we   (Prog_we),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   typedef struct {
      logic [31:0] word;
      logic [7:0]  addr;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  wr_addr[$];
   logic [31:0] wr_data[$];
   int          overlap_cnt = 0;
   int          we_in_run   = 0;
   logic [31:0] frame_words[256];
   vec_t        vecs[5];

   always @(negedge clk) begin
      if (!reset && Prog_we) begin
         wr_addr.push_back(Addr_Prog);
         wr_data.push_back(Data_Prog);
         if (ProgMode) we_in_run++;
      end
      if (!reset && ProgMode && cpu_reset) overlap_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         total++;
         bad++;
         $display("FAIL rx_ready_wait: byte %0h never accepted", b);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cnt, input int nwords, input int gap);
      logic [7:0] x;
      logic [7:0] bv;
      x = 8'h00;
      send_byte(8'hA5, gap);
      send_byte(cnt, gap);
      for (int w = 0; w < nwords; w++) begin
         for (int b = 3; b >= 0; b--) begin
            bv = frame_words[w][8*b +: 8];
            x  = x ^ bv;
            send_byte(bv, gap);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x, gap);
`endif
   endtask

   task automatic wait_end(input string name);
      int n = 0;
      while (!done && !error && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done && !error) begin
         total++;
         bad++;
         $display("FAIL %s: no done/error within 100 cycles", name);
      end
   endtask

   task automatic check_five(input string name, input int n0, input int gap);
      int ov0;
      ov0 = overlap_cnt;
      for (int i = 0; i < 5; i++) frame_words[i] = vecs[i].word;
      pulse_start();
      check({name, "_busy"}, busy, 1);
      check({name, "_progmode_load"}, ProgMode, 0);
      send_frame(8'h05, 5, gap);
      wait_end(name);
      check({name, "_writes"}, wr_addr.size() - n0, 5);
      for (int i = 0; i < 5; i++) begin
         if (n0 + i < wr_addr.size()) begin
            check({name, "_addr"}, wr_addr[n0+i], vecs[i].addr);
            check({name, "_data"}, wr_data[n0+i], vecs[i].word);
         end
      end
      check({name, "_overlap"}, overlap_cnt - ov0, 1);
      check({name, "_done"}, done, 1);
      check({name, "_error"}, error, 0);
      check({name, "_progmode_run"}, ProgMode, 1);
      check({name, "_cpu_reset_run"}, cpu_reset, 0);
      check({name, "_busy_run"}, busy, 0);
   endtask

   initial begin
      int n0;
      int k;
      int errs;
      logic [7:0] junk[3];

      vecs[0] = '{32'h10200005, 8'd0};
      vecs[1] = '{32'h10400003, 8'd1};
      vecs[2] = '{32'h00000004, 8'd2};
      vecs[3] = '{32'h00811005, 8'd3};
      vecs[4] = '{32'h00211004, 8'd4};
      junk[0] = 8'h00;
      junk[1] = 8'hFF;
      junk[2] = 8'h13;

      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_progmode", ProgMode, 1);
      check("rst_addr", Addr_Prog, 0);
      check("rst_data", Data_Prog, 0);
      check("rst_we", Prog_we, 0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_cpu_reset", cpu_reset, 0);
      check("idle_progmode", ProgMode, 1);

      // Basic five-word load.
      check_five("loadA", wr_addr.size(), 0);

      // Junk before sync and 3-cycle gaps between bytes.
      n0 = wr_addr.size();
      pulse_start();
      for (int i = 0; i < 3; i++) send_byte(junk[i], 3);
      check("junk_no_write", wr_addr.size() - n0, 0);
      check_five("loadB", wr_addr.size(), 3);

      // Count byte 0 means 256 words; the last lands at 255.
      n0 = wr_addr.size();
      for (int i = 0; i < 256; i++) frame_words[i] = 32'hC0DE0000 | i;
      pulse_start();
      send_frame(8'h00, 256, 0);
      wait_end("load256");
      check("load256_writes", wr_addr.size() - n0, 256);
      errs = 0;
      for (int i = 0; i < 256 && n0 + i < wr_addr.size(); i++) begin
         if (wr_addr[n0+i] !== 8'(i) || wr_data[n0+i] !== (32'hC0DE0000 | i)) errs++;
      end
      check("load256_seq_errs", errs, 0);
      if (wr_addr.size() > 0) begin
         check("load256_last_addr", wr_addr[wr_addr.size()-1], 8'hFF);
         check("load256_last_data", wr_data[wr_addr.size()-1], 32'hC0DE00FF);
      end
      check("load256_done", done, 1);

      // Stall after two data bytes: error exactly 50 cycles after the last accept.
      n0 = wr_addr.size();
      pulse_start();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      k = 0;
      while (!error && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("timeout_cycles", k, 50);
      check("timeout_error", error, 1);
      check("timeout_progmode", ProgMode, 0);
      check("timeout_cpu_reset", cpu_reset, 1);
      check("timeout_busy", busy, 0);
      check("timeout_rx_ready", rx_ready, 0);
      repeat (5) @(negedge clk);
      check("timeout_no_write", wr_addr.size() - n0, 0);
      pulse_start();
      check("resync_error_clr", error, 0);
      check_five("reload", wr_addr.size(), 0);

`ifdef LOADER_CHECKSUM_EN
      // Good checksum: 12^34^56^78 = 08.
      n0 = wr_addr.size();
      pulse_start();
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      send_byte(8'h08, 0);
      wait_end("chk_good");
      check("chk_good_done", done, 1);
      check("chk_good_error", error, 0);
      pulse_start();
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      send_byte(8'h09, 0);
      wait_end("chk_bad");
      check("chk_bad_error", error, 1);
      check("chk_bad_progmode", ProgMode, 0);
      check("chk_writes", wr_addr.size() - n0, 2);
      check("chk_bad_data_kept", Data_Prog, 32'h12345678);
`endif

      // Reset while assembling the third word of a three-word frame.
      for (int i = 0; i < 3; i++) frame_words[i] = vecs[i].word;
      pulse_start();
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      for (int w = 0; w < 2; w++) begin
         for (int b = 3; b >= 0; b--) send_byte(frame_words[w][8*b +: 8], 0);
      end
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("mid_addr", Addr_Prog, 1);
      check("mid_data", Data_Prog, 32'h10400003);
      check("mid_progmode", ProgMode, 0);
      reset = 1'b1;
      @(negedge clk);
      check("mrst_progmode", ProgMode, 1);
      check("mrst_addr", Addr_Prog, 0);
      check("mrst_data", Data_Prog, 0);
      check("mrst_busy", busy, 0);
      check("mrst_cpu_reset", cpu_reset, 1);
      check("mrst_rx_ready", rx_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      check("mrst_after_cpu_reset", cpu_reset, 0);
      check("mrst_after_done", done, 0);
      check("mrst_after_error", error, 0);

      check("we_while_run", we_in_run, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
